// File: rtl/wallace_tree_multiplier_pkg.sv
// Elaboration-time helpers that size the Wallace reduction layers.
package wallace_tree_multiplier_pkg;

    // Each 3:2 layer turns every group of three rows into two; leftovers pass through.
    function automatic int rows_after(input int rows);
        return 2 * (rows / 3) + rows % 3;
    endfunction

    function automatic int rows_at_layer(input int rows0, input int layer);
        int r;
        r = rows0;
        for (int li = 0; li < layer; li++) begin
            r = rows_after(r);
        end
        return r;
    endfunction

    function automatic int num_layers(input int rows0);
        int r;
        int cnt;
        r = rows0;
        cnt = 0;
        while (r > 2) begin
            r = rows_after(r);
            cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/wallace_tree_multiplier_csa_full_adder.sv
// Single-bit 3:2 carry-save cell used by the reduction layers and the final adder.
module csa_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/wallace_tree_multiplier.sv
// Two-stage signed NxN multiplier: operand registers, Wallace reduction and ripple adder, product register.
module wallace_tree_multiplier
    import wallace_tree_multiplier_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           en,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    output logic [2*N-1:0] Z
);
    localparam int W       = 2 * N;
    localparam int PP_ROWS = N + 1;
    localparam int LAYERS  = num_layers(PP_ROWS);

    logic [N-1:0] x_reg;
    logic [N-1:0] y_reg;
    logic [W-1:0] z_reg;
    logic [W-1:0] product;
    logic [W-1:0] x_ext;
    logic [W-1:0] pp [PP_ROWS];

    assign x_ext = {{N{x_reg[N-1]}}, x_reg};

    // Y's sign bit carries weight -2^(N-1): its row is stored inverted and the +1 goes in an extra row.
    genvar gi, gj, gk;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_pp
            assign pp[gi] = y_reg[gi] ? (x_ext << gi) : '0;
        end
    endgenerate
    assign pp[N-1] = y_reg[N-1] ? ~(x_ext << (N - 1)) : '0;
    assign pp[N]   = {{(W-1){1'b0}}, y_reg[N-1]};

    generate
        for (gi = 0; gi < LAYERS; gi++) begin : layer
            localparam int RIN    = rows_at_layer(PP_ROWS, gi);
            localparam int ROUT   = rows_after(RIN);
            localparam int GROUPS = RIN / 3;

            logic [W-1:0] in_rows  [RIN];
            logic [W-1:0] out_rows [ROUT];

            if (gi == 0) begin : g_src
                for (gj = 0; gj < RIN; gj++) begin : g_row
                    assign in_rows[gj] = pp[gj];
                end
            end else begin : g_src
                for (gj = 0; gj < RIN; gj++) begin : g_row
                    assign in_rows[gj] = layer[gi-1].out_rows[gj];
                end
            end

            for (gj = 0; gj < GROUPS; gj++) begin : csa
                logic [W-1:0] a;
                logic [W-1:0] b;
                logic [W-1:0] c;
                logic [W-1:0] s;
                logic [W-2:0] cy;

                assign a = in_rows[3*gj];
                assign b = in_rows[3*gj+1];
                assign c = in_rows[3*gj+2];

                for (gk = 0; gk < W - 1; gk++) begin : bit_fa
                    csa_full_adder u_fa (
                        .a   (a[gk]),
                        .b   (b[gk]),
                        .cin (c[gk]),
                        .sum (s[gk]),
                        .cout(cy[gk])
                    );
                end
                // Carry out of the top column falls outside the 2N-bit product.
                assign s[W-1] = a[W-1] ^ b[W-1] ^ c[W-1];

                assign out_rows[2*gj]   = s;
                assign out_rows[2*gj+1] = {cy, 1'b0};
            end

            for (gj = 0; gj < RIN % 3; gj++) begin : g_pass
                assign out_rows[2*GROUPS+gj] = in_rows[3*GROUPS+gj];
            end
        end
    endgenerate

    logic [W-1:0] row_a;
    logic [W-1:0] row_b;
    logic [W-1:1] carry;

    assign row_a = layer[LAYERS-1].out_rows[0];
    assign row_b = layer[LAYERS-1].out_rows[1];

    assign product[0] = row_a[0] ^ row_b[0];
    assign carry[1]   = row_a[0] & row_b[0];

    generate
        for (gk = 1; gk < W - 1; gk++) begin : g_cpa
            csa_full_adder u_fa (
                .a   (row_a[gk]),
                .b   (row_b[gk]),
                .cin (carry[gk]),
                .sum (product[gk]),
                .cout(carry[gk+1])
            );
        end
    endgenerate
    assign product[W-1] = row_a[W-1] ^ row_b[W-1] ^ carry[W-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
            z_reg <= '0;
        end else if (en) begin
            x_reg <= X;
            y_reg <= Y;
            z_reg <= product;
        end
    end

    assign Z = z_reg;

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Directed bench for the two-stage signed multiplier with hand-computed products.
module tb_wallace_tree_multiplier;
    localparam int N = 32;

    logic          clock;
    logic          reset;
    logic          en;
    logic [N-1:0]  X;
    logic [N-1:0]  Y;
    logic [2*N-1:0] Z;

    int compared;
    int mismatched;

    wallace_tree_multiplier #(.N(N)) dut (
        .clock(clock),
        .reset(reset),
        .en   (en),
        .X    (X),
        .Y    (Y),
        .Z    (Z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*N-1:0] expected);
        compared++;
        assert (Z === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, Z, expected);
        end
        $display("check %-14s X=%h Y=%h Z=%h expected=%h", tag, X, Y, Z, expected);
    endtask

    task automatic vec(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv,
                       input logic [2*N-1:0] expected);
        X = xv;
        Y = yv;
        step();
        step();
        check(tag, expected);
    endtask

    logic [N-1:0]   sx [6];
    logic [N-1:0]   sy [6];
    logic [2*N-1:0] se [6];

    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b1;
        en    = 1'b1;
        X     = 32'd2;
        Y     = 32'd4;

        step();
        check("reset_z", 64'd0);
        reset = 1'b0;
        step();
        check("latency_k", 64'd0);
        step();
        check("basic_2x4", 64'd8);

        vec("large_pos", 32'h0008_0002, 32'h0400_0004, 64'h0000_2000_0820_0008);
        vec("zero_x",    32'd0,          32'h0400_0004, 64'd0);
        vec("ident_x",   32'd1,          32'h0400_0004, 64'h0000_0000_0400_0004);
        vec("neg2x4",    -32'sd2,        32'd4,         -64'sd8);
        vec("2xneg3",    32'd2,          -32'sd3,       -64'sd6);
        vec("neg2xneg4", -32'sd2,        -32'sd4,       64'd8);
        vec("neg7xneg4", -32'sd7,        -32'sd4,       64'd28);
        vec("min_x_min", 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000);
        vec("m1_x_min",  32'hFFFF_FFFF,  32'h8000_0000, 64'h0000_0000_8000_0000);
        vec("max_x_min", 32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000);
        vec("neg5x1",    -32'sd5,        32'd1,         -64'sd5);

        // Back-to-back stream: Z after each edge is the product from one vector earlier.
        sx[0] = 32'd3;      sy[0] = 32'd5;      se[0] = 64'd15;
        sx[1] = -32'sd3;    sy[1] = 32'd5;      se[1] = -64'sd15;
        sx[2] = 32'd100;    sy[2] = -32'sd100;  se[2] = -64'sd10000;
        sx[3] = 32'd65536;  sy[3] = 32'd65536;  se[3] = 64'h0000_0001_0000_0000;
        sx[4] = -32'sd1;    sy[4] = -32'sd1;    se[4] = 64'd1;
        sx[5] = 32'd12345;  sy[5] = -32'sd2;    se[5] = -64'sd24690;
        for (int i = 0; i < 6; i++) begin
            X = sx[i];
            Y = sy[i];
            step();
            if (i >= 1) check($sformatf("stream_%0d", i - 1), se[i-1]);
        end
        X = 32'd0;
        Y = 32'd0;
        step();
        check("stream_5", se[5]);

        // Stall with both pipeline stages full.
        X = 32'd7;     Y = 32'd6;    step();
        X = -32'sd9;   Y = 32'd9;    step();
        check("pre_stall", 64'd42);
        en = 1'b0;
        X = 32'd99;    Y = 32'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_%0d", i), 64'd42);
        end
        en = 1'b1;
        X = 32'd11;    Y = -32'sd11;
        step();
        check("resume_1", -64'sd81);
        step();
        check("resume_2", -64'sd121);

        // Reset while operands are in flight.
        X = 32'd5;     Y = 32'd5;    step();
        X = 32'd6;     Y = 32'd6;    step();
        check("pre_reset", 64'd25);
        reset = 1'b1;
        step();
        check("mid_reset", 64'd0);
        reset = 1'b0;
        X = 32'd2;     Y = 32'd3;
        step();
        check("post_reset0", 64'd0);
        step();
        check("post_reset1", 64'd6);

        en    = 1'b0;
        reset = 1'b1;
        step();
        check("reset_no_en", 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
